pmu_cfg_counter_regs: RTL and testbench
=======================================

// Module: pmu_cfg_counter_regs
// PURPOSE
//  AXI-Lite 32-bit register slave terminating the PMU config port of the host/cluster AXI-Lite xbar
//  (window 0x1040_4000). Holds NumCounters free-running event counters fed by 1-cycle event pulses.
//  Provides per-counter enable, sticky overflow flags and atomic 64-bit reads via a high-word shadow.
// PARAMETERS
//  NumCounters     8         number of event counters, 1..16
//  CntWidth        48        counter width in bits, 33..64
//  AddrDecodeBits  12        low address bits decoded; upper bits ignored
//  req_lite_t      ariane_axi_soc::req_lite_t    AXI-Lite request struct
//  resp_lite_t     ariane_axi_soc::resp_lite_t   AXI-Lite response struct
// PORTS
//  clk_i           in   1            clock
//  rst_i           in   1            asynchronous, active-high reset
//  axi_lite_req_i  in   req_lite_t   AXI-Lite request from xbar master port
//  axi_lite_resp_o out  resp_lite_t  AXI-Lite response to xbar
//  evt_i           in   NumCounters  event pulses, one increment per cycle per set bit
//  ovf_irq_o       out  1            overflow interrupt (PMU_OVF_IRQ_EN only; else tied 0)
// BEHAVIOUR
//  Reset: all readies, b_valid, r_valid, ovf_irq_o = 0; all counters, CTRL, CNT_EN, STATUS, shadow = 0.
//  Register map (offset = addr[AddrDecodeBits-1:0], word aligned, addr[1:0] ignored):
//   0x000 CTRL   [0] global enable; [1] clear-all, write-1 pulse, reads 0
//   0x004 STATUS [NumCounters-1:0] sticky overflow, write-1-to-clear
//   0x008 IRQ_EN [NumCounters-1:0] overflow irq mask
//   0x00C CNT_EN [NumCounters-1:0] per-counter enable
//   0x100+8*i LO counter i bits [31:0]; a read latches bits [CntWidth-1:32] into shadow
//   0x104+8*i HI returns shadow (zero-extended); a write loads counter bits [CntWidth-1:32]
//  Write channel: 1 outstanding. aw_ready=w_ready=1 for one cycle only when aw_valid & w_valid & !b_pending;
//   register update on that edge, wstrb honoured per byte; b_valid next cycle, held until b_ready.
//  Read channel: 1 outstanding. ar_ready=1 when ar_valid & !r_pending; data sampled on accept edge,
//   r_valid next cycle, r_data/r_resp stable until r_ready.
//  FSMs: write IDLE->RESP(b_valid)->IDLE on b_ready; read IDLE->RESP(r_valid)->IDLE on r_ready.
//   Read and write channels run independently; both may accept in the same cycle.
//  Unmapped offset or counter index >= NumCounters: resp SLVERR, r_data 32'h0, write ignored.
//  Counting: counter i increments when CTRL[0] & CNT_EN[i] & evt_i[i]. All-ones + increment -> 0, STATUS[i] set.
//  Same-cycle priority per counter: clear-all > software write > increment (event lost).
//  STATUS: overflow set beats W1C clear in same cycle. Read+write same register same cycle: read returns pre-write value.
//  Reset mid-transaction: outstanding B/R dropped, FSMs to IDLE; xbar is reset by the same reset.
// CONFIGURATION
//  PMU_OVF_IRQ_EN defined: ovf_irq_o = |(STATUS & IRQ_EN), registered (1 cycle after STATUS update), level.
//  PMU_OVF_IRQ_EN undefined: IRQ_EN reads 0, writes OKAY but ignored; ovf_irq_o = 0.
// STRUCTURE
//  Package pmu_cfg_pkg: register offset localparams, CTRL bit indices, counter window base 0x100/stride 8,
//   write/read FSM state enums.
//  Sub-module pmu_event_counter (CntWidth): inputs en, inc, clr, ld_lo/ld_hi + data; outputs value, ovf pulse;
//   instantiated NumCounters times via generate.
// TESTING
//  1. CTRL=1, CNT_EN=0x1, 10 pulses on evt_i[0] -> LO0 reads 10, HI0 reads 0, other counters 0.
//  2. Write LO0=0xFFFF_FFFF, HI0=0xFFFF, one event -> LO0=0, HI0=0, STATUS=0x1; W1C 0x1 -> STATUS=0.
//  3. LO0=0xFFFF_FFFF, counting on: read LO0, then event, then read HI0 -> HI0 returns pre-carry shadow 0.
//  4. Read 0x200 (index 32) and 0x010 -> r_resp=SLVERR, r_data=0; write there -> b_resp=SLVERR, state unchanged.
//  5. aw_valid held 3 cycles before w_valid -> no ready until both valid; b_ready low 5 cycles -> b_valid held, no new accept.
//  6. PMU_OVF_IRQ_EN: IRQ_EN=0x4, overflow counter 2 -> ovf_irq_o=1 next cycle; W1C 0x4 -> 0; without macro stays 0.

Source files
------------

// File: rtl/pmu_cfg_pkg.sv
// Shared definitions for the PMU configuration register slave: AXI-Lite
// request/response structs (default port types of pmu_cfg_counter_regs),
// register offsets, CTRL bit positions, counter window geometry and the
// channel FSM state encodings.
package pmu_cfg_pkg;

    typedef struct packed {
        logic [31:0] addr;
    } axi_lite_addr_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } axi_lite_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axi_lite_b_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } axi_lite_r_t;

    typedef struct packed {
        axi_lite_addr_t aw;
        logic           aw_valid;
        axi_lite_w_t    w;
        logic           w_valid;
        logic           b_ready;
        axi_lite_addr_t ar;
        logic           ar_valid;
        logic           r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic           aw_ready;
        logic           w_ready;
        axi_lite_b_t    b;
        logic           b_valid;
        logic           ar_ready;
        axi_lite_r_t    r;
        logic           r_valid;
    } axi_lite_resp_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register offsets within the decoded window
    localparam logic [31:0] OFF_CTRL   = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFF_IRQ_EN = 32'h0000_0008;
    localparam logic [31:0] OFF_CNT_EN = 32'h0000_000C;

    // Counter window: LO at CNT_BASE + 8*i, HI at CNT_BASE + 8*i + 4
    localparam logic [31:0] CNT_BASE        = 32'h0000_0100;
    localparam int unsigned CNT_STRIDE_LOG2 = 3;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_CLR_BIT = 1;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_STATUS,
        SEL_IRQ_EN,
        SEL_CNT_EN,
        SEL_CNT_LO,
        SEL_CNT_HI
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [7:0] idx;
    } reg_dec_t;

endpackage

// File: rtl/pmu_event_counter.sv
// One PMU event counter of CntWidth bits (33..64). Priority on a given
// edge: clear > software load (LO or HI half) > increment. ovf_o flags,
// combinationally, that the increment taken on the coming edge wraps the
// counter from all-ones to zero.
module pmu_event_counter #(
    parameter int unsigned CntWidth = 48
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                inc_i,
    input  logic                clr_i,
    input  logic                ld_lo_i,
    input  logic                ld_hi_i,
    input  logic [31:0]         ld_data_i,
    input  logic [31:0]         ld_mask_i,
    output logic [CntWidth-1:0] value_o,
    output logic                ovf_o
);

    localparam int unsigned HI_W = CntWidth - 32;

    logic [CntWidth-1:0] r_value;
    logic [31:0]         w_lo_merged;
    logic [HI_W-1:0]     w_hi_merged;
    logic                w_inc;

    // Byte-lane merge so partial-strobe writes only touch the enabled bytes
    assign w_lo_merged = (r_value[31:0] & ~ld_mask_i) | (ld_data_i & ld_mask_i);
    assign w_hi_merged = (r_value[CntWidth-1:32] & ~ld_mask_i[HI_W-1:0])
                       | (ld_data_i[HI_W-1:0] & ld_mask_i[HI_W-1:0]);

    assign w_inc = en_i & inc_i;
    // An increment lost to a clear or a load must not raise overflow
    assign ovf_o = w_inc & (&r_value) & ~clr_i & ~ld_lo_i & ~ld_hi_i;
    assign value_o = r_value;

    // Counter state: clear beats load beats increment
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_value <= '0;
        end else if (clr_i) begin
            r_value <= '0;
        end else if (ld_lo_i) begin
            r_value[31:0] <= w_lo_merged;
        end else if (ld_hi_i) begin
            r_value[CntWidth-1:32] <= w_hi_merged;
        end else if (w_inc) begin
            r_value <= r_value + 1'b1;
        end
    end

endmodule

// File: rtl/pmu_cfg_counter_regs.sv
// AXI-Lite register slave for the PMU config port: NumCounters event
// counters with global/per-counter enable, sticky W1C overflow flags and
// atomic wide reads (a LO read latches the upper counter bits into a shared
// shadow that the HI register returns). One outstanding write and one
// outstanding read; the two channels run independently.
// Optional feature macro: PMU_OVF_IRQ_EN (IRQ_EN register + ovf_irq_o).
module pmu_cfg_counter_regs
    import pmu_cfg_pkg::*;
#(
    parameter int unsigned NumCounters    = 8,
    parameter int unsigned CntWidth       = 48,
    parameter int unsigned AddrDecodeBits = 12,
    parameter type         req_lite_t     = pmu_cfg_pkg::axi_lite_req_t,
    parameter type         resp_lite_t    = pmu_cfg_pkg::axi_lite_resp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  req_lite_t              axi_lite_req_i,
    output resp_lite_t             axi_lite_resp_o,
    input  logic [NumCounters-1:0] evt_i,
    output logic                   ovf_irq_o
);

    localparam int unsigned HI_W = CntWidth - 32;
    localparam logic [31:0] ADDR_MASK = (AddrDecodeBits >= 32) ? 32'hFFFF_FFFF
                                      : ((32'd1 << AddrDecodeBits) - 32'd1);

    // Map an address to a register selector; counter slots past NumCounters
    // and holes in the map decode to SEL_NONE (SLVERR).
    function automatic reg_dec_t decode(input logic [31:0] addr);
        logic [31:0] off;
        logic [31:0] rel;
        reg_dec_t    d;
        off   = addr & ADDR_MASK & 32'hFFFF_FFFC;
        rel   = off - CNT_BASE;
        d.sel = SEL_NONE;
        d.idx = '0;
        case (off)
            OFF_CTRL:   d.sel = SEL_CTRL;
            OFF_STATUS: d.sel = SEL_STATUS;
            OFF_IRQ_EN: d.sel = SEL_IRQ_EN;
            OFF_CNT_EN: d.sel = SEL_CNT_EN;
            default: begin
                if ((off >= CNT_BASE) && ((rel >> CNT_STRIDE_LOG2) < NumCounters)) begin
                    d.idx = rel[10:3];
                    d.sel = rel[2] ? SEL_CNT_HI : SEL_CNT_LO;
                end
            end
        endcase
        return d;
    endfunction

    wr_state_e              r_wr_state;
    rd_state_e              r_rd_state;
    logic                   r_b_valid;
    logic [1:0]             r_b_resp;
    logic                   r_r_valid;
    logic [31:0]            r_r_data;
    logic [1:0]             r_r_resp;
    logic [HI_W-1:0]        r_shadow;
    logic                   r_ctrl_en;
    logic [NumCounters-1:0] r_cnt_en;
    logic [NumCounters-1:0] r_status;

    reg_dec_t               w_wr_dec;
    reg_dec_t               w_rd_dec;
    logic                   w_wr_accept;
    logic                   w_rd_accept;
    logic [31:0]            w_be_mask;
    logic [NumCounters-1:0] w_wdata_n;
    logic [NumCounters-1:0] w_mask_n;
    logic                   w_clr_all;
    logic [NumCounters-1:0] w_ld_lo;
    logic [NumCounters-1:0] w_ld_hi;
    logic [NumCounters-1:0] w_ovf;
    logic [NumCounters-1:0] w_status_w1c;
    logic [NumCounters-1:0] w_status_next;
    logic [CntWidth-1:0]    w_cnt_value [NumCounters];
    logic [CntWidth-1:0]    w_cnt_sel;
    logic [31:0]            w_rd_data;
    logic [1:0]             w_rd_resp;

    assign w_wr_dec = decode(axi_lite_req_i.aw.addr);
    assign w_rd_dec = decode(axi_lite_req_i.ar.addr);

    // AW and W are taken together, and only with no B response pending
    assign w_wr_accept = axi_lite_req_i.aw_valid & axi_lite_req_i.w_valid
                       & (r_wr_state == W_IDLE);
    assign w_rd_accept = axi_lite_req_i.ar_valid & (r_rd_state == R_IDLE);

    for (genvar gi = 0; gi < 4; gi++) begin : g_be
        assign w_be_mask[gi*8 +: 8] = {8{axi_lite_req_i.w.strb[gi]}};
    end

    assign w_wdata_n = axi_lite_req_i.w.data[NumCounters-1:0];
    assign w_mask_n  = w_be_mask[NumCounters-1:0];
    assign w_clr_all = w_wr_accept & (w_wr_dec.sel == SEL_CTRL)
                     & axi_lite_req_i.w.strb[0] & axi_lite_req_i.w.data[CTRL_CLR_BIT];

    for (genvar gi = 0; gi < NumCounters; gi++) begin : g_cnt
        assign w_ld_lo[gi] = w_wr_accept & (w_wr_dec.sel == SEL_CNT_LO) & (w_wr_dec.idx == 8'(gi));
        assign w_ld_hi[gi] = w_wr_accept & (w_wr_dec.sel == SEL_CNT_HI) & (w_wr_dec.idx == 8'(gi));

        pmu_event_counter #(
            .CntWidth (CntWidth)
        ) u_cnt (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (r_ctrl_en & r_cnt_en[gi]),
            .inc_i     (evt_i[gi]),
            .clr_i     (w_clr_all),
            .ld_lo_i   (w_ld_lo[gi]),
            .ld_hi_i   (w_ld_hi[gi]),
            .ld_data_i (axi_lite_req_i.w.data),
            .ld_mask_i (w_be_mask),
            .value_o   (w_cnt_value[gi]),
            .ovf_o     (w_ovf[gi])
        );
    end

    // A fresh overflow wins over a W1C of the same bit on the same edge
    assign w_status_w1c  = (w_wr_accept && (w_wr_dec.sel == SEL_STATUS)) ? (w_wdata_n & w_mask_n) : '0;
    assign w_status_next = (r_status & ~w_status_w1c) | w_ovf;

    // Control, enable and sticky status registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ctrl_en <= 1'b0;
            r_cnt_en  <= '0;
            r_status  <= '0;
        end else begin
            if (w_wr_accept && (w_wr_dec.sel == SEL_CTRL) && axi_lite_req_i.w.strb[0]) begin
                r_ctrl_en <= axi_lite_req_i.w.data[CTRL_EN_BIT];
            end
            if (w_wr_accept && (w_wr_dec.sel == SEL_CNT_EN)) begin
                r_cnt_en <= (r_cnt_en & ~w_mask_n) | (w_wdata_n & w_mask_n);
            end
            r_status <= w_status_next;
        end
    end

`ifdef PMU_OVF_IRQ_EN
    logic [NumCounters-1:0] r_irq_en;
    logic                   r_ovf_irq;

    // Interrupt mask register and registered level interrupt
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_irq_en  <= '0;
            r_ovf_irq <= 1'b0;
        end else begin
            if (w_wr_accept && (w_wr_dec.sel == SEL_IRQ_EN)) begin
                r_irq_en <= (r_irq_en & ~w_mask_n) | (w_wdata_n & w_mask_n);
            end
            r_ovf_irq <= |(r_status & r_irq_en);
        end
    end

    assign ovf_irq_o = r_ovf_irq;
`else
    assign ovf_irq_o = 1'b0;
`endif

    // Pick the counter addressed by the read channel
    always_comb begin
        w_cnt_sel = '0;
        for (int i = 0; i < NumCounters; i++) begin
            if (w_rd_dec.idx == 8'(i)) begin
                w_cnt_sel = w_cnt_value[i];
            end
        end
    end

    // Read data mux; values are the pre-update register contents
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_rd_dec.sel)
            SEL_CTRL:   w_rd_data[CTRL_EN_BIT] = r_ctrl_en;
            SEL_STATUS: w_rd_data[NumCounters-1:0] = r_status;
            SEL_IRQ_EN: begin
`ifdef PMU_OVF_IRQ_EN
                w_rd_data[NumCounters-1:0] = r_irq_en;
`endif
            end
            SEL_CNT_EN: w_rd_data[NumCounters-1:0] = r_cnt_en;
            SEL_CNT_LO: w_rd_data = w_cnt_sel[31:0];
            SEL_CNT_HI: w_rd_data[HI_W-1:0] = r_shadow;
            default:    w_rd_resp = RESP_SLVERR;
        endcase
    end

    // Write response FSM: IDLE -> RESP on accept, back on b_ready
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_state <= W_IDLE;
            r_b_valid  <= 1'b0;
            r_b_resp   <= RESP_OKAY;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_wr_accept) begin
                        r_wr_state <= W_RESP;
                        r_b_valid  <= 1'b1;
                        r_b_resp   <= (w_wr_dec.sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                W_RESP: begin
                    if (axi_lite_req_i.b_ready) begin
                        r_wr_state <= W_IDLE;
                        r_b_valid  <= 1'b0;
                    end
                end
                default: begin
                    r_wr_state <= W_IDLE;
                    r_b_valid  <= 1'b0;
                end
            endcase
        end
    end

    // Read response FSM: capture data on accept, hold until r_ready
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_state <= R_IDLE;
            r_r_valid  <= 1'b0;
            r_r_data   <= '0;
            r_r_resp   <= RESP_OKAY;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_rd_accept) begin
                        r_rd_state <= R_RESP;
                        r_r_valid  <= 1'b1;
                        r_r_data   <= w_rd_data;
                        r_r_resp   <= w_rd_resp;
                    end
                end
                R_RESP: begin
                    if (axi_lite_req_i.r_ready) begin
                        r_rd_state <= R_IDLE;
                        r_r_valid  <= 1'b0;
                    end
                end
                default: begin
                    r_rd_state <= R_IDLE;
                    r_r_valid  <= 1'b0;
                end
            endcase
        end
    end

    // High-word shadow: snapshot taken by every accepted LO read
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shadow <= '0;
        end else if (w_rd_accept && (w_rd_dec.sel == SEL_CNT_LO)) begin
            r_shadow <= w_cnt_sel[CntWidth-1:32];
        end
    end

    // Drive the response struct
    always_comb begin
        axi_lite_resp_o          = '0;
        axi_lite_resp_o.aw_ready = w_wr_accept;
        axi_lite_resp_o.w_ready  = w_wr_accept;
        axi_lite_resp_o.b_valid  = r_b_valid;
        axi_lite_resp_o.b.resp   = r_b_resp;
        axi_lite_resp_o.ar_ready = w_rd_accept;
        axi_lite_resp_o.r_valid  = r_r_valid;
        axi_lite_resp_o.r.data   = r_r_data;
        axi_lite_resp_o.r.resp   = r_r_resp;
    end

endmodule

// File: tb/tb_pmu_cfg_counter_regs.sv
// Bench for pmu_cfg_counter_regs: a table of register accesses followed by
// hand-written multi-cycle sequences. Expected responses are queued when a
// transaction is issued and popped when the DUT answers.
module tb_pmu_cfg_counter_regs;
    import pmu_cfg_pkg::*;

    localparam int NC     = 8;
    localparam int BUDGET = 50;
    localparam logic [31:0] IRQ_EN_RD =
`ifdef PMU_OVF_IRQ_EN
        32'h4;
`else
        32'h0;
`endif
    localparam logic [31:0] IRQ_LVL =
`ifdef PMU_OVF_IRQ_EN
        32'h1;
`else
        32'h0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    axi_lite_req_t  req;
    axi_lite_resp_t resp;
    logic [NC-1:0]  evt;
    logic           irq;

    always #5 clk = ~clk;

    pmu_cfg_counter_regs #(
        .NumCounters    (NC),
        .CntWidth       (48),
        .AddrDecodeBits (12),
        .req_lite_t     (axi_lite_req_t),
        .resp_lite_t    (axi_lite_resp_t)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .axi_lite_req_i  (req),
        .axi_lite_resp_o (resp),
        .evt_i           (evt),
        .ovf_irq_o       (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bound(input string name, input int n);
        n_checks++;
        if (n >= BUDGET) begin
            n_fail++;
            $display("FAIL %s: no handshake within %0d cycles", name, BUDGET);
        end
    endtask

    task automatic axi_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp);
        sb_t e;
        int  n;
        e.name = name; e.exp_data = 32'h0; e.exp_resp = exp_resp;
        sb_q.push_back(e);
        @(negedge clk);
        req.aw.addr = addr; req.aw_valid = 1'b1;
        req.w.data = data; req.w.strb = strb; req.w_valid = 1'b1;
        req.b_ready = 1'b1;
        n = 0;
        while (!(resp.aw_ready && resp.w_ready) && n < BUDGET) begin @(negedge clk); n++; end
        check_bound({name, "_aw"}, n);
        @(posedge clk); #1;
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        n = 0;
        while (!resp.b_valid && n < BUDGET) begin @(negedge clk); n++; end
        check_bound({name, "_b"}, n);
        e = sb_q.pop_front();
        check({e.name, "_bresp"}, {30'h0, resp.b.resp}, {30'h0, e.exp_resp});
        $display("WR %-14s addr=%08h data=%08h strb=%h bresp=%0d", name, addr, data, strb, resp.b.resp);
        @(posedge clk); #1;
        req.b_ready = 1'b0;
    endtask

    task automatic axi_read(input string name, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        sb_t e;
        int  n;
        e.name = name; e.exp_data = exp_data; e.exp_resp = exp_resp;
        sb_q.push_back(e);
        @(negedge clk);
        req.ar.addr = addr; req.ar_valid = 1'b1; req.r_ready = 1'b1;
        n = 0;
        while (!resp.ar_ready && n < BUDGET) begin @(negedge clk); n++; end
        check_bound({name, "_ar"}, n);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        n = 0;
        while (!resp.r_valid && n < BUDGET) begin @(negedge clk); n++; end
        check_bound({name, "_r"}, n);
        e = sb_q.pop_front();
        check({e.name, "_rdata"}, resp.r.data, e.exp_data);
        check({e.name, "_rresp"}, {30'h0, resp.r.resp}, {30'h0, e.exp_resp});
        $display("RD %-14s addr=%08h data=%08h rresp=%0d", name, addr, resp.r.data, resp.r.resp);
        @(posedge clk); #1;
        req.r_ready = 1'b0;
    endtask

    task automatic pulse_evt(input logic [NC-1:0] m, input int n);
        @(negedge clk);
        evt = m;
        repeat (n) @(negedge clk);
        evt = '0;
    endtask

    function automatic void add_vec(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                                    input logic [3:0] strb, input logic [31:0] exp_data,
                                    input logic [1:0] exp_resp, input string name);
        vec_t v;
        v.is_wr = is_wr; v.addr = addr; v.data = data; v.strb = strb;
        v.exp_data = exp_data; v.exp_resp = exp_resp; v.name = name;
        vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b1;
        req = '0;
        evt = '0;

        // Register-access table: reset values, strobes, decode and errors
        add_vec(0, 32'h000, 0, 0, 32'h0, RESP_OKAY, "ctrl_rst");
        add_vec(0, 32'h004, 0, 0, 32'h0, RESP_OKAY, "status_rst");
        add_vec(0, 32'h00C, 0, 0, 32'h0, RESP_OKAY, "cnten_rst");
        add_vec(0, 32'h100, 0, 0, 32'h0, RESP_OKAY, "lo0_rst");
        add_vec(1, 32'h00C, 32'h0000_01A5, 4'hF, 0, RESP_OKAY, "cnten_wr");
        add_vec(0, 32'h00C, 0, 0, 32'h0000_00A5, RESP_OKAY, "cnten_rd");
        add_vec(1, 32'h00C, 32'h0000_00FF, 4'h0, 0, RESP_OKAY, "cnten_nostrb");
        add_vec(0, 32'h00C, 0, 0, 32'h0000_00A5, RESP_OKAY, "cnten_kept");
        add_vec(1, 32'h008, 32'h0000_0004, 4'hF, 0, RESP_OKAY, "irqen_wr");
        add_vec(0, 32'h008, 0, 0, IRQ_EN_RD, RESP_OKAY, "irqen_rd");
        add_vec(0, 32'h010, 0, 0, 32'h0, RESP_SLVERR, "hole_rd");
        add_vec(0, 32'h200, 0, 0, 32'h0, RESP_SLVERR, "idx32_rd");
        add_vec(1, 32'h200, 32'hFFFF_FFFF, 4'hF, 0, RESP_SLVERR, "idx32_wr");
        add_vec(1, 32'h010, 32'hFFFF_FFFF, 4'hF, 0, RESP_SLVERR, "hole_wr");
        add_vec(0, 32'h004, 0, 0, 32'h0, RESP_OKAY, "status_unchg");
        add_vec(0, 32'h13C, 0, 0, 32'h0, RESP_OKAY, "hi7_rd");
        add_vec(0, 32'h140, 0, 0, 32'h0, RESP_SLVERR, "idx8_rd");
        add_vec(1, 32'h000, 32'h0000_0003, 4'hF, 0, RESP_OKAY, "ctrl_wr_clr");
        add_vec(0, 32'h000, 0, 0, 32'h1, RESP_OKAY, "ctrl_rd");
        add_vec(0, 32'h1040_4000, 0, 0, 32'h1, RESP_OKAY, "ctrl_alias");
        add_vec(1, 32'h000, 32'h0, 4'hF, 0, RESP_OKAY, "ctrl_off");
        add_vec(1, 32'h00C, 32'h0, 4'hF, 0, RESP_OKAY, "cnten_off");
        add_vec(0, 32'h103, 0, 0, 32'h0, RESP_OKAY, "lo0_unalign");

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bvalid",  {31'h0, resp.b_valid},  32'h0);
        check("rst_rvalid",  {31'h0, resp.r_valid},  32'h0);
        check("rst_awready", {31'h0, resp.aw_ready}, 32'h0);
        check("rst_irq",     {31'h0, irq},           32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rvalid", {31'h0, resp.r_valid}, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) axi_write(vecs[i].name, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
            else               axi_read(vecs[i].name, vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
        end

        // Basic counting; counter 1 sees events but is disabled
        axi_write("ctrl_en", 32'h000, 32'h1, 4'hF, RESP_OKAY);
        axi_write("cnten_c0", 32'h00C, 32'h1, 4'hF, RESP_OKAY);
        pulse_evt(8'h03, 10);
        axi_read("lo0_10", 32'h100, 32'd10, RESP_OKAY);
        axi_read("hi0_0", 32'h104, 32'd0, RESP_OKAY);
        axi_read("lo1_0", 32'h108, 32'd0, RESP_OKAY);
        axi_read("lo2_0", 32'h110, 32'd0, RESP_OKAY);
        axi_write("ctrl_gl_off", 32'h000, 32'h0, 4'hF, RESP_OKAY);
        pulse_evt(8'h01, 5);
        axi_read("lo0_frozen", 32'h100, 32'd10, RESP_OKAY);
        axi_write("ctrl_gl_on", 32'h000, 32'h1, 4'hF, RESP_OKAY);

        // Full-width wrap sets sticky overflow, W1C clears it
        axi_write("lo0_ones", 32'h100, 32'hFFFF_FFFF, 4'hF, RESP_OKAY);
        axi_write("hi0_ones", 32'h104, 32'h0000_FFFF, 4'hF, RESP_OKAY);
        axi_read("lo0_ones_rd", 32'h100, 32'hFFFF_FFFF, RESP_OKAY);
        axi_read("hi0_ones_rd", 32'h104, 32'h0000_FFFF, RESP_OKAY);
        pulse_evt(8'h01, 1);
        axi_read("lo0_wrap", 32'h100, 32'h0, RESP_OKAY);
        axi_read("hi0_wrap", 32'h104, 32'h0, RESP_OKAY);
        axi_read("status_ovf", 32'h004, 32'h1, RESP_OKAY);
        axi_write("status_w1c", 32'h004, 32'h1, 4'hF, RESP_OKAY);
        axi_read("status_clr", 32'h004, 32'h0, RESP_OKAY);

        // Shadow keeps the pre-carry high word
        axi_write("lo0_ones2", 32'h100, 32'hFFFF_FFFF, 4'hF, RESP_OKAY);
        axi_read("lo0_snap", 32'h100, 32'hFFFF_FFFF, RESP_OKAY);
        pulse_evt(8'h01, 1);
        axi_read("hi0_shadow", 32'h104, 32'h0, RESP_OKAY);
        axi_read("lo0_carry", 32'h100, 32'h0, RESP_OKAY);
        axi_read("hi0_carry", 32'h104, 32'h1, RESP_OKAY);
        axi_read("status_nowrap", 32'h004, 32'h0, RESP_OKAY);

        // Clear-all pulse zeroes counters and reads back 0
        axi_write("ctrl_clrall", 32'h000, 32'h3, 4'hF, RESP_OKAY);
        axi_read("ctrl_clr_rd", 32'h000, 32'h1, RESP_OKAY);
        axi_read("lo0_cleared", 32'h100, 32'h0, RESP_OKAY);
        axi_read("hi0_cleared", 32'h104, 32'h0, RESP_OKAY);

        // Overflow interrupt on counter 2
        axi_write("cnten_c2", 32'h00C, 32'h4, 4'hF, RESP_OKAY);
        axi_write("lo2_ones", 32'h110, 32'hFFFF_FFFF, 4'hF, RESP_OKAY);
        axi_write("hi2_ones", 32'h114, 32'h0000_FFFF, 4'hF, RESP_OKAY);
        @(negedge clk);
        evt = 8'h04;
        @(negedge clk);
        evt = '0;
        check("irq_same_edge", {31'h0, irq}, 32'h0);
        @(negedge clk);
        check("irq_next_cycle", {31'h0, irq}, IRQ_LVL);
        axi_read("status_c2", 32'h004, 32'h4, RESP_OKAY);
        axi_write("status_nostrb", 32'h004, 32'h4, 4'h0, RESP_OKAY);
        axi_read("status_c2_kept", 32'h004, 32'h4, RESP_OKAY);
        check("irq_held", {31'h0, irq}, IRQ_LVL);
        axi_write("status_w1c2", 32'h004, 32'h4, 4'hF, RESP_OKAY);
        @(negedge clk);
        check("irq_cleared", {31'h0, irq}, 32'h0);

        // AW ahead of W, then B back-pressure with a second write waiting
        @(negedge clk);
        req.aw.addr = OFF_CNT_EN; req.aw_valid = 1'b1;
        req.w.data = 32'h1; req.w.strb = 4'hF; req.w_valid = 1'b0; req.b_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("aw_only_noready", {30'h0, resp.aw_ready, resp.w_ready}, 32'h0);
            @(negedge clk);
        end
        req.w_valid = 1'b1;
        #1;
        check("aw_w_ready", {30'h0, resp.aw_ready, resp.w_ready}, 32'h3);
        @(posedge clk); #1;
        req.w.data = 32'h3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bhold_bvalid", {31'h0, resp.b_valid}, 32'h1);
            check("bhold_noaccept", {31'h0, resp.aw_ready}, 32'h0);
        end
        check("bhold_bresp", {30'h0, resp.b.resp}, {30'h0, RESP_OKAY});
        $display("WR %-14s addr=%08h data=%08h strb=f bresp=%0d", "cnten_delayed", OFF_CNT_EN, 32'h1, resp.b.resp);
        req.b_ready = 1'b1;
        @(posedge clk); #1;
        check("second_wr_ready", {31'h0, resp.aw_ready}, 32'h1);
        @(posedge clk); #1;
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        check("second_wr_bvalid", {31'h0, resp.b_valid}, 32'h1);
        $display("WR %-14s addr=%08h data=%08h strb=f bresp=%0d", "cnten_queued", OFF_CNT_EN, 32'h3, resp.b.resp);
        @(posedge clk); #1;
        req.b_ready = 1'b0;
        axi_read("cnten_after", 32'h00C, 32'h3, RESP_OKAY);

        // R back-pressure: data held stable, no second accept
        @(negedge clk);
        req.ar.addr = OFF_CNT_EN; req.ar_valid = 1'b1; req.r_ready = 1'b0;
        #1;
        check("rhold_arready", {31'h0, resp.ar_ready}, 32'h1);
        @(posedge clk); #1;
        req.ar.addr = OFF_CTRL;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rhold_rvalid", {31'h0, resp.r_valid}, 32'h1);
            check("rhold_data", resp.r.data, 32'h3);
            check("rhold_noaccept", {31'h0, resp.ar_ready}, 32'h0);
        end
        $display("RD %-14s addr=%08h data=%08h rresp=%0d", "cnten_hold", OFF_CNT_EN, resp.r.data, resp.r.resp);
        req.ar_valid = 1'b0; req.r_ready = 1'b1;
        @(posedge clk); #1;
        req.r_ready = 1'b0;
        @(negedge clk);
        check("rhold_done", {31'h0, resp.r_valid}, 32'h0);

        // Reset with a read response outstanding
        @(negedge clk);
        req.ar.addr = OFF_CNT_EN; req.ar_valid = 1'b1; req.r_ready = 1'b0;
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        check("midrst_rvalid_pre", {31'h0, resp.r_valid}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_rvalid", {31'h0, resp.r_valid}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        axi_read("ctrl_after_rst", 32'h000, 32'h0, RESP_OKAY);
        axi_read("cnten_after_rst", 32'h00C, 32'h0, RESP_OKAY);
        axi_read("lo2_after_rst", 32'h110, 32'h0, RESP_OKAY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
